// File: rtl/sort_serializer.sv
// rtl/sort_serializer.sv - group FIFO feeding a 4-beat serializer for sorted number groups
module sort_serializer #(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_in_valid,
    input  logic [4:0]               i_in_number1,
    input  logic [4:0]               i_in_number2,
    input  logic [4:0]               i_in_number3,
    input  logic [4:0]               i_in_number4,
    input  logic                     i_out_ready,
    output logic                     o_out_valid,
    output logic [4:0]               o_out_number,
    output logic                     o_out_first,
    output logic                     o_out_last,
    output logic [$clog2(DEPTH):0]   o_fifo_count,
    output logic                     o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SEND = 1'b1;

    logic [19:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_state;
    logic [1:0]    r_idx;
    logic [19:0]   r_group;

    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Pop when idle, or on the final beat so back-to-back groups leave no bubble.
    assign w_pop  = !w_empty && ((r_state == ST_IDLE) ||
                                (i_out_ready && (r_idx == 2'd3)));
    // A pop in the same edge frees a slot, so a full FIFO still accepts.
    assign w_push = i_in_valid && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_in_number1, i_in_number2, i_in_number3, i_in_number4};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (i_in_valid && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= 2'd0;
            r_group <= '0;
        end else if (w_pop) begin
            r_state <= ST_SEND;
            r_idx   <= 2'd0;
            r_group <= r_mem[r_rd_ptr];
        end else if ((r_state == ST_SEND) && i_out_ready) begin
            if (r_idx == 2'd3) begin
                r_state <= ST_IDLE;
            end
            r_idx <= r_idx + 2'd1;
        end
    end

    always_comb begin
        o_out_number = 5'd0;
        if (r_state == ST_SEND) begin
            case (r_idx)
                2'd0:    o_out_number = r_group[19:15];
                2'd1:    o_out_number = r_group[14:10];
                2'd2:    o_out_number = r_group[9:5];
                default: o_out_number = r_group[4:0];
            endcase
        end
    end

    assign o_out_valid  = (r_state == ST_SEND);
    assign o_out_first  = (r_state == ST_SEND) && (r_idx == 2'd0);
    assign o_out_last   = (r_state == ST_SEND) && (r_idx == 2'd3);
    assign o_fifo_count = r_count;
    assign o_overflow   = r_overflow;

endmodule

// File: doc/sort_serializer.md
SORT_SERIALIZER -- requirements
Module: sort_serializer

Interface
REQ-001: Parameter DEPTH, default 4, group-FIFO depth in groups; power of 2, minimum 2.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: in_valid  input  1  a sorted group is present this cycle; driven by the upstream sort pipeline's out_valid.
REQ-005: in_number1..in_number4  input  5 each  sorted group, in_number1 largest to in_number4 smallest.
REQ-006: out_ready  input  1  downstream accepts the current beat.
REQ-007: out_valid  output  1  out_number holds a valid beat.
REQ-008: out_number  output  5  serialized value.
REQ-009: out_first  output  1  current beat is element 1 of its group.
REQ-010: out_last  output  1  current beat is element 4 of its group.
REQ-011: fifo_count  output  $clog2(DEPTH)+1  groups stored in the FIFO, excluding the group in the serializer.
REQ-012: overflow  output  1  sticky flag: at least one group was dropped.

Function
REQ-013: The upstream interface has no backpressure, so the block shall accept in_valid in any cycle, including consecutive cycles.
REQ-014: On a rising edge with in_valid=1 and the FIFO not full, the block shall push all four numbers as one FIFO entry.
REQ-015: On a rising edge with in_valid=1, the FIFO full, and no pop in the same cycle, the block shall discard the group, set overflow=1, and leave the FIFO unchanged.
REQ-016: On a rising edge with a simultaneous push and pop, the push shall succeed when the FIFO is full and fifo_count shall remain unchanged.
REQ-017: The serializer shall have states IDLE and SEND, with a 2-bit beat index from 0 to 3.
REQ-018: In IDLE with the FIFO non-empty, the next edge shall pop the head into a 4-word output register, enter SEND, and set index=0.
REQ-019: In SEND, a beat transfers on an edge where out_valid=1 and out_ready=1, and the index then increments.
REQ-020: On transfer of the index-3 beat, the serializer shall pop the next group in the same edge if the FIFO is non-empty, with no bubble; otherwise it shall return to IDLE.
REQ-021: In SEND the block shall drive out_valid=1 and out_number=element[index], with element 1 emitted first.
REQ-022: In SEND the block shall drive out_first=1 when index=0 and out_last=1 when index=3.
REQ-023: While out_valid=1 and out_ready=0, out_number, out_first and out_last shall remain stable.
REQ-024: In IDLE the block shall drive out_valid=0, out_number=0, out_first=0 and out_last=0.
REQ-025: Latency shall be 2 cycles: with an empty FIFO and the serializer IDLE, in_valid in cycle N gives out_valid=1 in cycle N+2.
REQ-026: With out_ready held at 1, each group shall take exactly 4 consecutive out_valid cycles.
REQ-027: All outputs shall be registered or decoded only from registers, with no combinational path from any input to any output.
REQ-028: The FIFO read and write pointers shall wrap modulo DEPTH.
REQ-029: Full shall be defined as fifo_count=DEPTH and empty as fifo_count=0.

Reset
REQ-030: While rst_n=0, the block shall hold out_valid=0, out_number=0, out_first=0, out_last=0, fifo_count=0 and overflow=0, with the serializer in IDLE and the pointers at 0.
REQ-031: Assertion of rst_n mid-group shall abort the partial group immediately and discard all FIFO contents.
REQ-032: After rst_n deasserts, the first edge with in_valid=1 shall be accepted normally.
REQ-033: overflow shall clear only on reset.

Verification
REQ-034: Single group {20,13,7,2} in cycle 0 with out_ready=1 -> out_number 20,13,7,2 in cycles 2-5; out_first only in cycle 2; out_last only in cycle 5.
REQ-035: Three back-to-back groups with out_ready=1 -> 12 contiguous out_valid beats; out_last followed directly by out_first; fifo_count peaks at 2 and returns to 0.
REQ-036: out_ready=0 for 3 cycles mid-group (index 1) -> out_number holds element 2 and no beat is lost or duplicated.
REQ-037: out_ready=0 and DEPTH+2 groups pushed in consecutive cycles -> first group in the serializer, next DEPTH groups in the FIFO, last group dropped; overflow=1 and fifo_count=DEPTH; all kept groups then emerge in order.
REQ-038: FIFO full with the final beat transferring and in_valid=1 in the same cycle -> push accepted, fifo_count stays DEPTH, overflow stays 0.
REQ-039: rst_n pulsed low during beat index 2 -> all outputs 0 asynchronously; a new group afterwards emerges with 2-cycle latency.
